// File: rtl/fp16_pkg.sv
// FP16 field widths, word layout and operand classification shared by the FP16 datapath blocks.
package fp16_pkg;

    localparam int FP16_EXP_W  = 5;
    localparam int FP16_FRAC_W = 10;
    localparam int FP16_BIAS   = 15;
    localparam int FP16_W      = 1 + FP16_EXP_W + FP16_FRAC_W;

    localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX = 5'h1F;

    typedef struct packed {
        logic                   sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [FP16_FRAC_W-1:0] frac;
    } fp16_t;

    typedef enum logic [2:0] {
        ZERO,
        DENORM,
        NORMAL,
        INF,
        NAN
    } fp16_class_e;

    function automatic fp16_class_e fp16_classify(input fp16_t x);
        fp16_class_e cls;
        if (x.exp == FP16_EXP_MAX) begin
            cls = (x.frac == '0) ? INF : NAN;
        end else if (x.exp == '0) begin
            cls = (x.frac == '0) ? ZERO : DENORM;
        end else begin
            cls = NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp16_unpack.sv
// Combinational FP16 field decode: sign, mantissa with hidden bit, effective exponent, class.
// Zero latency, no handshake; denormals report exponent 1 so the mantissa scale stays uniform.
module fp16_unpack
    import fp16_pkg::*;
(
    input  logic [FP16_W-1:0]      word_i,
    output logic                   sign_o,
    output logic [FP16_FRAC_W:0]   mant_o,
    output logic [FP16_EXP_W-1:0]  exp_o,
    output fp16_class_e            cls_o
);

    fp16_t w;

    assign w = fp16_t'(word_i);

    always_comb begin
        sign_o = w.sign;
        mant_o = {(w.exp != '0), w.frac};
        exp_o  = (w.exp == '0) ? FP16_EXP_W'(1) : w.exp;
        cls_o  = fp16_classify(w);
    end

endmodule

// File: rtl/fp16_to_fixed.sv
// FP16 to signed Q(OUT_W-FRAC_W).FRAC_W converter, 2-cycle latency, 1 item/cycle.
// Valid/ready on both sides; in_ready depends only on out_ready and the two stage valids.
module fp16_to_fixed
    import fp16_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP16_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat,
    output logic              out_nan
);

    localparam int SH_W       = 8;
    localparam int MANT_W     = FP16_FRAC_W + 1;
    localparam int SHL_MAX    = 5 + FRAC_W;
    localparam int MAG_W      = MANT_W + ((SHL_MAX > 0) ? SHL_MAX : 0) + 1;
    localparam int CMP_W      = ((MAG_W > OUT_W) ? MAG_W : OUT_W) + 1;
    localparam int RND_W      = MANT_W + 2;
    localparam int RND_MAX_SH = MANT_W + 1;

    localparam logic signed [SH_W-1:0] SH_OFS  = SH_W'(FRAC_W - FP16_BIAS - FP16_FRAC_W);
    localparam logic [CMP_W-1:0]       NEG_LIM = CMP_W'(1) << (OUT_W - 1);
    localparam logic [CMP_W-1:0]       POS_LIM = NEG_LIM - CMP_W'(1);
    localparam logic [OUT_W-1:0]       MAX_OUT = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]       MIN_OUT = {1'b1, {(OUT_W-1){1'b0}}};

    logic adv1;
    logic adv2;

    logic                   u_sign;
    logic [MANT_W-1:0]      u_mant;
    logic [FP16_EXP_W-1:0]  u_exp;
    fp16_class_e            u_cls;

    logic                   s1_vld_q, s1_vld_d;
    logic                   s1_sign_q, s1_sign_d;
    logic [MANT_W-1:0]      s1_mant_q, s1_mant_d;
    logic signed [SH_W-1:0] s1_sh_q, s1_sh_d;
    logic                   s1_inf_q, s1_inf_d;
    logic                   s1_nan_q, s1_nan_d;
    logic                   s1_ld;

    logic                   out_vld_q, out_vld_d;
    logic [OUT_W-1:0]       out_data_q, out_data_d;
    logic                   out_sat_q, out_sat_d;
    logic                   out_nan_q, out_nan_d;
    logic                   out_ld;

    logic                   sh_neg;
    logic [SH_W-1:0]        sh_abs;
    logic [MAG_W-1:0]       mag_shl;
    logic [RND_W-1:0]       rnd_sum;
    logic [CMP_W-1:0]       mag;

    assign adv2     = !out_vld_q || out_ready;
    assign adv1     = !s1_vld_q || adv2;
    assign in_ready = adv1;

    assign out_valid = out_vld_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_nan   = out_nan_q;

    fp16_unpack u_unpack (
        .word_i (in_data),
        .sign_o (u_sign),
        .mant_o (u_mant),
        .exp_o  (u_exp),
        .cls_o  (u_cls)
    );

    always_comb begin
        s1_ld     = adv1 && in_valid;
        s1_vld_d  = adv1 ? in_valid : s1_vld_q;
        s1_sign_d = u_sign;
        s1_mant_d = u_mant;
        s1_sh_d   = $signed({{(SH_W-FP16_EXP_W){1'b0}}, u_exp}) + SH_OFS;
        s1_inf_d  = (u_cls == INF);
        s1_nan_d  = (u_cls == NAN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_mant_q <= '0;
            s1_sh_q   <= '0;
            s1_inf_q  <= 1'b0;
            s1_nan_q  <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            if (s1_ld) begin
                s1_sign_q <= s1_sign_d;
                s1_mant_q <= s1_mant_d;
                s1_sh_q   <= s1_sh_d;
                s1_inf_q  <= s1_inf_d;
                s1_nan_q  <= s1_nan_d;
            end
        end
    end

    // Right shifts round half away from zero on the magnitude; beyond 12 places even a
    // full mantissa plus the half-LSB bias cannot reach 1, so the result is simply 0.
    always_comb begin
        sh_neg  = s1_sh_q[SH_W-1];
        sh_abs  = sh_neg ? (~s1_sh_q + SH_W'(1)) : s1_sh_q;
        mag_shl = MAG_W'(s1_mant_q) << sh_abs;
        rnd_sum = RND_W'(s1_mant_q) + (RND_W'(1) << (sh_abs - SH_W'(1)));
        mag     = '0;
        if (!sh_neg) begin
            mag = CMP_W'(mag_shl);
        end else if (sh_abs <= SH_W'(RND_MAX_SH)) begin
            mag = CMP_W'(rnd_sum >> sh_abs);
        end
    end

    always_comb begin
        out_ld     = adv2 && s1_vld_q;
        out_vld_d  = adv2 ? s1_vld_q : out_vld_q;
        out_data_d = '0;
        out_sat_d  = 1'b0;
        out_nan_d  = 1'b0;
        if (s1_nan_q) begin
            out_nan_d = 1'b1;
        end else if (s1_inf_q) begin
            out_data_d = s1_sign_q ? MIN_OUT : MAX_OUT;
            out_sat_d  = 1'b1;
        end else if (s1_sign_q) begin
            if (mag > NEG_LIM) begin
                out_data_d = MIN_OUT;
                out_sat_d  = 1'b1;
            end else begin
                out_data_d = OUT_W'(~mag + CMP_W'(1));
            end
        end else begin
            if (mag > POS_LIM) begin
                out_data_d = MAX_OUT;
                out_sat_d  = 1'b1;
            end else begin
                out_data_d = mag[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            out_nan_q  <= 1'b0;
        end else begin
            out_vld_q <= out_vld_d;
            if (out_ld) begin
                out_data_q <= out_data_d;
                out_sat_q  <= out_sat_d;
                out_nan_q  <= out_nan_d;
            end
        end
    end

endmodule

// File: tb/tb_fp16_to_fixed.sv
// Scoreboard bench for fp16_to_fixed: directed vectors plus a random sweep against a real-number model.
module tb_fp16_to_fixed;

    localparam int OUT_W  = 16;
    localparam int FRAC_W = 8;
    localparam logic [OUT_W-1:0] PMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NMIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [15:0]      in_data   = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             out_nan;

    fp16_to_fixed #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_nan   (out_nan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      src;
        logic [OUT_W-1:0] dat;
        logic             sat;
        logic             nan;
        logic             lat;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   total      = 0;
    int   bad        = 0;
    int   cyc        = 0;
    int   rdy_mode   = 0;
    int   in_low_cnt = 0;
    logic             hold_vld = 1'b0;
    logic [OUT_W+1:0] hold_val = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready: 0 = always ready, 1 = random, 2 = stalled
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (!in_ready) in_low_cnt++;
            if (out_valid) begin
                if (hold_vld)
                    chk("hold_stable", 32'({out_data, out_sat, out_nan}), 32'(hold_val));
                if (out_ready) begin
                    hold_vld = 1'b0;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got 0x%0h with empty scoreboard, want no output", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("data[%h]", e.src), 32'(out_data), 32'(e.dat));
                        chk($sformatf("sat[%h]", e.src), 32'(out_sat), 32'(e.sat));
                        chk($sformatf("nan[%h]", e.src), 32'(out_nan), 32'(e.nan));
                        if (e.lat)
                            chk($sformatf("latency[%h]", e.src), 32'(cyc - e.cyc), 32'd2);
                    end
                end else begin
                    hold_vld = 1'b1;
                    hold_val = {out_data, out_sat, out_nan};
                end
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    // Real-valued reference: value * 2^FRAC_W, rounded half away from zero, then clipped.
    function automatic void model(input logic [15:0] w, output logic [OUT_W-1:0] d,
                                  output logic s, output logic n);
        logic [4:0] e;
        int         m;
        int         ex;
        real        r;
        longint     mag;
        e = w[14:10];
        d = '0;
        s = 1'b0;
        n = 1'b0;
        if (e == 5'h1F) begin
            if (w[9:0] != 10'd0) begin
                n = 1'b1;
            end else begin
                s = 1'b1;
                d = w[15] ? NMIN : PMAX;
            end
        end else begin
            m   = (e != 5'd0) ? 1024 + int'(w[9:0]) : int'(w[9:0]);
            ex  = (e != 5'd0) ? int'(e) : 1;
            r   = real'(m) * (2.0 ** real'(ex - 25 + FRAC_W));
            mag = longint'($floor(r + 0.5));
            if (!w[15]) begin
                if (mag > longint'(2 ** (OUT_W - 1) - 1)) begin
                    d = PMAX;
                    s = 1'b1;
                end else begin
                    d = OUT_W'(mag);
                end
            end else if (mag > longint'(2 ** (OUT_W - 1))) begin
                d = NMIN;
                s = 1'b1;
            end else begin
                d = OUT_W'(-mag);
            end
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] w, input logic [OUT_W-1:0] d,
                        input logic s, input logic n, input logic lat);
        exp_t e;
        int   waitc = 0;
        e.src = w;
        e.dat = d;
        e.sat = s;
        e.nan = n;
        e.lat = lat;
        e.cyc = 0;
        in_valid = 1'b1;
        in_data  = w;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.cyc = cyc;
                sb.push_back(e);
                break;
            end
            waitc++;
            if (waitc > 200) begin
                total++;
                bad++;
                $display("FAIL in_ready_timeout: in_ready held 0 for 200 cycles, want 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0]      w;
        logic [OUT_W-1:0] d;
        logic             s;
        logic             n;
        int               lc0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_sat",   32'(out_sat),   32'd0);
        chk("rst_out_nan",   32'(out_nan),   32'd0);
        @(posedge clk);
        #1;

        // basic values, back-to-back, latency tracked
        send(16'h3C00, 16'h0100, 1'b0, 1'b0, 1'b1);
        send(16'hC100, 16'hFD80, 1'b0, 1'b0, 1'b1);
        // rounding and zeros
        send(16'h1800, 16'h0001, 1'b0, 1'b0, 1'b0);
        send(16'h9800, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        send(16'h3C01, 16'h0100, 1'b0, 1'b0, 1'b0);
        send(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
        send(16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0);
        // saturation and specials
        send(16'h5A40, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        send(16'hD800, 16'h8000, 1'b0, 1'b0, 1'b0);
        send(16'h7C00, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        send(16'hFC00, 16'h8000, 1'b1, 1'b0, 1'b0);
        send(16'h7E00, 16'h0000, 1'b0, 1'b1, 1'b0);
        drain();

        // backpressure: 4-cycle stall while streaming
        lc0 = in_low_cnt;
        fork
            begin
                send(16'h3C00, 16'h0100, 1'b0, 1'b0, 1'b0);
                send(16'h4000, 16'h0200, 1'b0, 1'b0, 1'b0);
                send(16'h4200, 16'h0300, 1'b0, 1'b0, 1'b0);
                send(16'hBC00, 16'hFF00, 1'b0, 1'b0, 1'b0);
                send(16'h3800, 16'h0080, 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                rdy_mode = 2;
                repeat (4) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();
        chk("in_ready_drop", 32'(in_low_cnt > lc0), 32'd1);

        // reset with two items in flight
        send(16'h3C00, 16'h0100, 1'b0, 1'b0, 1'b0);
        send(16'h4200, 16'h0300, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        send(16'h4000, 16'h0200, 1'b0, 1'b0, 1'b1);
        drain();

        // random sweep with random downstream readiness
        rdy_mode = 1;
        repeat (300) begin
            w = 16'($urandom);
            model(w, d, s, n);
            send(w, d, s, n, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp16_to_fixed.md
Name: fp16_to_fixed

Overview:
Streaming converter from FP16 results (adder/MAC outputs) to signed two's-complement fixed point, Q(OUT_W-FRAC_W).FRAC_W. It is the decode side of the FP16 datapath and feeds requantised activations to output buffers and integer post-processing. It is a 2-stage pipeline with valid/ready handshakes on both sides and accepts one item per cycle.

Parameters:
OUT_W, 16, total output width (two's complement); legal range 8..32
FRAC_W, 8, fractional bits of output; legal range 0..OUT_W-2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input word valid
in_ready  out  1  converter can accept input this cycle
in_data  in  16  FP16 operand (sign, 5-bit exp bias 15, 10-bit frac)
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts output this cycle
out_data  out  OUT_W  fixed-point result
out_sat  out  1  result was clipped (finite overflow or ±Inf)
out_nan  out  1  input was NaN; out_data is 0

Behaviour:
- One clock; reset is synchronous and active-high. Both ports named as in the rest of the codebase: clk, rst.
- Reset: out_valid=0, out_data=0, out_sat=0, out_nan=0, and both stage valids are 0. in_ready=1 in the first cycle after reset. Reset asserted mid-stream drops all in-flight items; out_valid=0 on the next edge.
- Handshake: a transfer occurs when valid&&ready are high at a rising edge.
  - out_data, out_sat and out_nan stay stable while out_valid=1 and out_ready=0.
  - A producer never deasserts valid without a transfer.
- Pipeline: S1 register (unpacked sign, 11-bit mantissa, signed shift, class flags) feeds the S2/output register.
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1. This is combinational from out_ready and registered valids only, with no path from in_valid.
  - Latency is 2 cycles (accepted at edge N, out_valid at edge N+2). Throughput is 1/cycle under no stall. Order is preserved, with no loss or duplication.
- Arithmetic:
  - Mantissa M = {e!=0, frac}. Effective exponent E = max(e,1).
  - Shift SH = E - 25 + FRAC_W, signed.
  - SH>=0: Mag = M<<SH, computed in an intermediate of width 11+max(0,5+FRAC_W)+1 so no bits are lost.
  - SH<0: Mag = (M + 2^(-SH-1)) >> -SH. This is round-half-away-from-zero applied to magnitude. If -SH>12, Mag=0.
  - Limits: positive max = 2^(OUT_W-1)-1; negative max magnitude = 2^(OUT_W-1).
  - If Mag exceeds the limit for the sign: out_data = max or min, out_sat=1. Otherwise out_data = sign ? -Mag : Mag, out_sat=0.
  - ±0 and denormals flowing to 0 give out_data=0 with no sign issue.
- Specials:
  - e=31, frac=0: +Inf gives 2^(OUT_W-1)-1, -Inf gives -2^(OUT_W-1); out_sat=1.
  - e=31, frac!=0: out_data=0, out_nan=1, out_sat=0.
- Flags are registered alongside out_data and valid only when out_valid=1.

Decomposition:
- fp16_pkg holds:
  - the FP16_EXP_W=5, FP16_FRAC_W=10 and FP16_BIAS=15 constants;
  - the FP16_EXP_MAX=5'h1F constant;
  - a packed struct fp16_t {sign, exp, frac};
  - a class enum {ZERO, DENORM, NORMAL, INF, NAN}.
- One combinational sub-module, fp16_unpack, produces sign, hidden-bit mantissa, effective exponent and class from a 16-bit word. It is reusable by the adder and multiplier. All sequencing stays in fp16_to_fixed.

Test Plan:
1. OUT_W=16, FRAC_W=8, out_ready=1, basic values:
   - 0x3C00 (1.0) -> 0x0100.
   - 0xC100 (-2.5) -> 0xFD80.
   - Each appears 2 cycles after acceptance; back-to-back inputs give back-to-back outputs.
2. Rounding:
   - 0x1800 (2^-9 = 0.5 LSB) -> 0x0001.
   - 0x9800 -> 0xFFFF.
   - 0x3C01 -> 0x0100.
   - 0x0001 (min denormal) -> 0x0000.
   - 0x8000 -> 0x0000.
3. Saturation/specials:
   - 0x5A40 (200.0) -> 0x7FFF, sat=1.
   - 0xD800 (-128.0) -> 0x8000, sat=0.
   - 0x7C00 -> 0x7FFF, sat=1.
   - 0xFC00 -> 0x8000, sat=1.
   - 0x7E00 -> 0x0000, nan=1.
4. Backpressure: stream 5 values with out_ready low for 4 cycles mid-stream.
   - out_data is held stable throughout the stall.
   - in_ready drops once both stages are full.
   - All 5 results arrive in order with no duplicates.
5. Reset mid-stream: assert rst for 1 cycle with 2 items in flight.
   - out_valid=0 and in_ready=1 the next cycle.
   - The dropped items never appear.
   - A new input 0x4000 -> 0x0200 after 2 cycles.
6. Random sweep: random 16-bit words and random out_ready, checked against a scoreboard real-number model. Results must match bit-exactly across all classes.
